// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, frame size and
// the common host-to-device command bytes.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SEND,
      ACK,
      WAIT_IDLE
   } ps2_tx_state_e;

   localparam int PS2_FRAME_BITS = 10;

   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between host-side logic and the PS/2 transmitter.
// master = command issuer, slave = ps2_host_tx.
interface ps2_host_tx_if;
   import ps2_pkg::*;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       ack_ok;
   logic       error;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, busy, done, ack_ok, error
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, busy, done, ack_ok, error
   );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 lines plus clock falling-edge
// detect; shared by the transmit and receive paths.
module ps2_line_sync (
   input  logic clk,
   input  logic rstn,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic clk_s,
   output logic data_s,
   output logic clk_fall
);

   logic [1:0] clk_q;
   logic [1:0] data_q;
   logic       clk_prev;

   // Idle lines read high, so reset to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clk_q    <= 2'b11;
         data_q   <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_q    <= {clk_q[0], ps2_clk_in};
         data_q   <= {data_q[0], ps2_data_in};
         clk_prev <= clk_q[1];
      end
   end

   assign clk_s    = clk_q[1];
   assign data_s   = data_q[1];
   assign clk_fall = clk_prev & ~clk_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (open-drain, drive 0 or Z).
// Optional PS2_TX_RETRY_EN: up to 2 automatic retries on no-ack/timeout.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic          clk,
   input  logic          rstn,
   inout  wire           ps2_clk,
   inout  wire           ps2_data,
   ps2_host_tx_if.slave  tx
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       PAR_BIT  = 4'(PS2_FRAME_BITS - 2);

   ps2_tx_state_e    state_q, state_d;
   logic [INH_W-1:0] inh_q, inh_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [3:0]       bit_q, bit_d;
   logic [8:0]       frame_q, frame_d;
   logic             ack_q, ack_d;
   logic             done_w;
   logic             wd_run;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]       retry_q, retry_d;
`endif

   logic clk_s, data_s, clk_fall;
   logic clk_low, data_low;

   ps2_line_sync u_sync (
      .clk         (clk),
      .rstn        (rstn),
      .ps2_clk_in  (ps2_clk),
      .ps2_data_in (ps2_data),
      .clk_s       (clk_s),
      .data_s      (data_s),
      .clk_fall    (clk_fall)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         inh_q   <= '0;
         wd_q    <= '0;
         bit_q   <= '0;
         frame_q <= '0;
         ack_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retry_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         inh_q   <= inh_d;
         wd_q    <= wd_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         ack_q   <= ack_d;
`ifdef PS2_TX_RETRY_EN
         retry_q <= retry_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      inh_d   = inh_q;
      wd_d    = wd_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      ack_d   = ack_q;
      done_w  = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_d = retry_q;
`endif
      wd_run = (state_q == REQ) || (state_q == SEND) || (state_q == ACK);
      if (wd_run)
         wd_d = clk_fall ? '0 : wd_q + WD_W'(1);

      unique case (state_q)
         IDLE: begin
            if (tx.tx_valid) begin
               frame_d = {odd_parity(tx.tx_data), tx.tx_data};
               ack_d   = 1'b0;
               inh_d   = '0;
`ifdef PS2_TX_RETRY_EN
               retry_d = '0;
`endif
               state_d = INHIBIT;
            end
         end
         INHIBIT: begin
            if (inh_q == INH_LAST) begin
               wd_d    = '0;
               bit_d   = '0;
               state_d = REQ;
            end else begin
               inh_d = inh_q + INH_W'(1);
            end
         end
         REQ: begin
            if (clk_fall)
               state_d = SEND;
         end
         SEND: begin
            if (clk_fall) begin
               bit_d = bit_q + 4'd1;
               if (bit_q == PAR_BIT)
                  state_d = ACK;
            end
         end
         ACK: begin
            if (clk_fall) begin
               ack_d   = ~data_s;
               bit_d   = bit_q + 4'd1;
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (clk_s && data_s) begin
`ifdef PS2_TX_RETRY_EN
               if (!ack_q && retry_q != 2'd2) begin
                  retry_d = retry_q + 2'd1;
                  inh_d   = '0;
                  state_d = INHIBIT;
               end else begin
                  done_w  = 1'b1;
                  state_d = IDLE;
               end
`else
               done_w  = 1'b1;
               state_d = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // Device stopped clocking: abandon the frame as a failure.
      if (wd_run && !clk_fall && wd_q == WD_LAST) begin
         ack_d   = 1'b0;
         state_d = WAIT_IDLE;
      end
   end

   assign clk_low  = (state_q == INHIBIT);
   assign data_low = ((state_q == INHIBIT) && (inh_q == INH_LAST))
                   || (state_q == REQ)
                   || ((state_q == SEND) && !frame_q[bit_q]);

   assign ps2_clk  = clk_low  ? 1'b0 : 1'bz;
   assign ps2_data = data_low ? 1'b0 : 1'bz;

   assign tx.tx_ready = (state_q == IDLE);
   assign tx.busy     = (state_q != IDLE);
   assign tx.done     = done_w;
   assign tx.ack_ok   = ack_q;
   assign tx.error    = done_w & ~ack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: pull-ups, PS/2 device model, frame/result
// scoreboards. Honours PS2_TX_RETRY_EN for the no-ack expectations.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 20;
   localparam int TMO = 400;
`ifdef PS2_TX_RETRY_EN
   localparam int NACK_FRAMES = 3;
`else
   localparam int NACK_FRAMES = 1;
`endif

   typedef struct {
      logic ack;
      logic err;
   } res_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   wire  ps2_clk;
   wire  ps2_data;
   logic dev_clk_low = 1'b0;
   logic dev_data_low = 1'b0;

   pullup (ps2_clk);
   pullup (ps2_data);
   assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
   assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

   ps2_host_tx_if tx_if ();

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .tx       (tx_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_rel = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   logic clk_pin_prev = 1'b1;
   logic [7:0] exp_frames[$];
   res_t exp_res[$];

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (clk_pin_prev === 1'b0 && ps2_clk === 1'b1)
         last_rel = cyc;
      clk_pin_prev = ps2_clk;
   end

   always @(negedge clk) begin
      res_t r;
      if (rstn && tx_if.done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
         check_eq("done_expected", 32'(exp_res.size() > 0), 1);
         if (exp_res.size() > 0) begin
            r = exp_res.pop_front();
            check_eq("ack_ok", 32'(tx_if.ack_ok), 32'(r.ack));
            check_eq("error", 32'(tx_if.error), 32'(r.err));
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      tx_if.tx_data  = b;
      tx_if.tx_valid = 1'b1;
      while (tx_if.tx_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      tx_if.tx_valid = 1'b0;
   endtask

   task automatic dev_wait_req(input bit chk_inh);
      int n = 0;
      while (ps2_clk !== 1'b0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_eq("inhibit_seen", 32'(ps2_clk === 1'b0), 1);
      n = 0;
      while (ps2_clk === 1'b0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (chk_inh)
         check_eq("inhibit_len", n, INH);
      check_eq("start_bit", 32'(ps2_data), 0);
      repeat (5) @(negedge clk);
   endtask

   task automatic dev_pulse(output logic smp);
      dev_clk_low = 1'b1;
      repeat (10) @(negedge clk);
      smp = ps2_data;
      dev_clk_low = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic dev_frame(input bit do_ack, input bit chk_inh);
      logic [9:0] bits;
      logic [7:0] e;
      logic       s;
      dev_wait_req(chk_inh);
      for (int i = 0; i < 10; i++) begin
         dev_pulse(s);
         bits[i] = s;
      end
      if (do_ack) begin
         dev_data_low = 1'b1;
         repeat (2) @(negedge clk);
         dev_pulse(s);
         dev_data_low = 1'b0;
      end else begin
         dev_pulse(s);
      end
      check_eq("frame_expected", 32'(exp_frames.size() > 0), 1);
      e = (exp_frames.size() > 0) ? exp_frames.pop_front() : 8'h00;
      check_eq("data_bits", 32'(bits[7:0]), 32'(e));
      check_eq("parity", 32'(bits[8]), 32'($countones(e) % 2 == 0));
      check_eq("stop", 32'(bits[9]), 1);
   endtask

   task automatic wait_done(input int target, input string tag);
      int n = 0;
      while (done_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_done"}, 32'(done_cnt >= target), 1);
   endtask

   initial begin
      int base;
      int d;
      logic s;
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 32'(tx_if.tx_ready), 1);
      check_eq("rst_busy", 32'(tx_if.busy), 0);
      check_eq("rst_done", 32'(tx_if.done), 0);
      check_eq("rst_ack", 32'(tx_if.ack_ok), 0);
      check_eq("rst_error", 32'(tx_if.error), 0);
      check_eq("rst_clk_z", 32'(ps2_clk), 1);
      check_eq("rst_data_z", 32'(ps2_data), 1);
      rstn = 1'b1;
      repeat (3) @(negedge clk);

      // 0xF4, acked
      exp_frames.push_back(PS2_CMD_ENABLE);
      exp_res.push_back('{ack: 1'b1, err: 1'b0});
      fork
         send(PS2_CMD_ENABLE);
         dev_frame(1'b1, 1'b0);
      join
      wait_done(1, "f4");
      repeat (5) @(negedge clk);

      // 0xFF, acked, inhibit length measured
      exp_frames.push_back(PS2_CMD_RESET);
      exp_res.push_back('{ack: 1'b1, err: 1'b0});
      fork
         send(PS2_CMD_RESET);
         dev_frame(1'b1, 1'b1);
      join
      wait_done(2, "ff");
      repeat (5) @(negedge clk);

      // device never clocks
      exp_res.push_back('{ack: 1'b0, err: 1'b1});
      send(8'h5A);
      wait_done(3, "timeout");
      d = done_cyc - last_rel;
      check_eq("timeout_window", 32'(d >= TMO && d <= TMO + 3), 1);
      check_eq("timeout_clk_z", 32'(ps2_clk), 1);
      check_eq("timeout_data_z", 32'(ps2_data), 1);
      repeat (5) @(negedge clk);

      // device omits ack
      base = done_cnt;
      for (int k = 0; k < NACK_FRAMES; k++)
         exp_frames.push_back(8'hA5);
      exp_res.push_back('{ack: 1'b0, err: 1'b1});
      fork
         send(8'hA5);
         for (int k = 0; k < NACK_FRAMES; k++)
            dev_frame(1'b0, 1'b0);
      join
      wait_done(base + 1, "noack");
      repeat (60) @(negedge clk);
      check_eq("noack_done_count", done_cnt - base, 1);
      check_eq("noack_frames_left", exp_frames.size(), 0);

      // tx_valid held through a busy transfer
      base = done_cnt;
      exp_frames.push_back(PS2_CMD_ENABLE);
      exp_frames.push_back(8'h00);
      exp_res.push_back('{ack: 1'b1, err: 1'b0});
      exp_res.push_back('{ack: 1'b1, err: 1'b0});
      fork
         begin
            int n = 0;
            @(negedge clk);
            tx_if.tx_data  = PS2_CMD_ENABLE;
            tx_if.tx_valid = 1'b1;
            @(negedge clk);
            check_eq("hold_busy", 32'(tx_if.busy), 1);
            tx_if.tx_data = 8'h00;
            while (tx_if.tx_ready !== 1'b1 && n < 5000) begin
               @(negedge clk);
               n++;
            end
            @(negedge clk);
            check_eq("hold_accept", 32'(tx_if.busy), 1);
            tx_if.tx_valid = 1'b0;
         end
         begin
            dev_frame(1'b1, 1'b0);
            dev_frame(1'b1, 1'b0);
         end
      join
      wait_done(base + 2, "hold");
      repeat (5) @(negedge clk);

      // reset during bit 4 of a 0x00 frame
      base = done_cnt;
      fork
         send(8'h00);
         begin
            dev_wait_req(1'b0);
            for (int i = 0; i < 5; i++)
               dev_pulse(s);
         end
      join
      check_eq("pre_rst_data_low", 32'(ps2_data), 0);
      #2 rstn = 1'b0;
      #1;
      check_eq("mid_rst_clk_z", 32'(ps2_clk), 1);
      check_eq("mid_rst_data_z", 32'(ps2_data), 1);
      repeat (5) @(negedge clk);
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("mid_rst_no_done", done_cnt - base, 0);
      check_eq("mid_rst_ready", 32'(tx_if.tx_ready), 1);

      exp_frames.push_back(PS2_CMD_SET_RATE);
      exp_res.push_back('{ack: 1'b1, err: 1'b0});
      fork
         send(PS2_CMD_SET_RATE);
         dev_frame(1'b1, 1'b0);
      join
      wait_done(base + 1, "f3");
      repeat (5) @(negedge clk);
      check_eq("res_left", exp_res.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 command transmitter. It takes one command byte from the host-side logic and drives the open-drain PS/2 lines through the full request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop, then device acknowledge. It sits beside the mouse packet reader on the same `ps2_clk`/`ps2_data` pins, and lets the mouse init sequencer issue 0xFF, 0xF4 and similar commands. It never drives a line high; it drives 0 or releases to Z.

## Interface
- `INHIBIT_CYCLES`, 5000: clk cycles `ps2_clk` is held low before the start bit (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: watchdog limit between device clock falling edges (15 ms at 50 MHz).
- `clk` input 1: system clock.
- `rstn` input 1: asynchronous, active-low reset.
- `ps2_clk` inout 1: open-drain PS/2 clock.
- `ps2_data` inout 1: open-drain PS/2 data.
- `tx_data` input 8: command byte, captured on accept.
- `tx_valid` input 1: request to send.
- `tx_ready` output 1: high only in IDLE; a transfer is accepted when `tx_valid && tx_ready`.
- `busy` output 1: high from accept until the return to IDLE.
- `done` output 1: one-cycle pulse at the end of every transfer, successful or not.
- `ack_ok` output 1: valid with `done`; 1 means the device acknowledged.
- `error` output 1: one-cycle pulse with `done` on timeout or missing ack.

## Operation
- Input path:
  - Both lines pass through a 2-flop synchronizer.
  - Falling edge of `ps2_clk` = synced previous 1, current 0.
- IDLE:
  - Both lines released.
  - On accept, latch `tx_data` and compute parity = ~^tx_data.
  - Go to INHIBIT.
- INHIBIT:
  - Drive `ps2_clk` low for INHIBIT_CYCLES cycles.
  - In the final cycle, also drive `ps2_data` low (start bit).
  - Go to REQ.
- REQ:
  - Release `ps2_clk`; keep `ps2_data` low.
  - Clear the bit counter and watchdog.
  - On the first falling edge, present data bit 0; go to SEND.
- SEND:
  - Each later falling edge presents the next bit: data bits 1..7, then parity, then stop (release data).
  - A data or parity bit of 1 is driven as release; a bit of 0 is driven low.
  - After the falling edge that presents stop, go to ACK.
- ACK:
  - On the next falling edge, sample synced `ps2_data`.
  - Sample = 0 sets ack_ok=1; sample = 1 sets ack_ok=0 (no-ack).
  - Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until both synced lines read 1.
  - Then pulse `done`, with `error` = ~ack_ok, and go to IDLE.
- Watchdog:
  - Counts in REQ, SEND and ACK; cleared on every `ps2_clk` falling edge.
  - Reaching TIMEOUT_CYCLES releases both lines, sets ack_ok=0, and forces WAIT_IDLE.
  - If the lines are then high, `done` + `error` pulse in the same cycle WAIT_IDLE is evaluated.
- `tx_valid` while busy is ignored. `tx_data` is not re-sampled after accept.
- Bit counter is 4 bits, range 0..10. Watchdog width is $clog2(TIMEOUT_CYCLES+1).

## Timing
- Reset values:
  - Both lines released (Z).
  - State IDLE, `tx_ready`=1.
  - `busy`, `done`, `ack_ok`, `error` all 0.
- Reset asserted mid-transfer releases both lines asynchronously. The partial frame is abandoned with no `done`.
- Accept at cycle N: `ps2_clk` is driven low from N+1. `ps2_data` is driven low at N+INHIBIT_CYCLES. Clock is released at N+INHIBIT_CYCLES+1.
- New data bit appears on the pin 3 clk cycles after a pin falling edge (2 sync + 1 register). This is well inside the device's half-period of ≥30 µs.
- `done` follows the pin-level line-idle condition by 3 cycles.
- `tx_ready` returns high the cycle after `done`.

## Configuration
- `PS2_TX_RETRY_EN`:
  - Defined: on a no-ack or timeout, the block re-enters INHIBIT with the same byte, up to 2 retries, without pulsing `done`. Only the final outcome pulses `done`/`error`. The retry counter clears on accept.
  - Undefined: every failure ends the transfer immediately with `done` + `error`.

## Structure
- Shared package `ps2_pkg`:
  - State encoding: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
  - Constant `PS2_FRAME_BITS`=10 (8 data, parity, stop).
  - Common PS/2 command constants: 0xFF reset, 0xF4 enable reporting, 0xF3 set sample rate.
- One sub-module, `ps2_line_sync`: 2-flop synchronizers for both lines plus `ps2_clk` falling-edge detect. It is shared with the receive path.

## Test plan
Bench uses pull-ups and a device model. Parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=400.
- Send 0xF4: device samples data bits 0,0,1,0,1,1,1,1, parity 0, stop 1; device acks → `done`=1, `ack_ok`=1, `error`=0.
- Send 0xFF: device samples eight 1s, parity 1 → ack → `ack_ok`=1. Verify `ps2_clk` is low for exactly 20 cycles before the start bit.
- Device never clocks after REQ → `done`+`error` 400–403 cycles after clock release; both lines are Z.
- Device omits ack (data stays high on the 11th edge) → without the macro, one `done` with `error`=1. With `PS2_TX_RETRY_EN`, three full frames are observed, then a single `done` with `error`=1.
- `tx_valid` held high with 0x00 during a busy 0xF4 transfer → only 0xF4 is transmitted. 0x00 is accepted on the cycle `tx_ready` rises.
- `rstn` asserted at bit 4 of a frame → lines Z within the same cycle, no `done`. After release, a new 0xF3 transfer completes with `ack_ok`=1.
